// File: rtl/sap_pkg.sv
// Shared constants and the per-edge operation decode for the SAP program counter.
// The return stack is compiled in only when PC_STACK_EN is defined.
package sap_pkg;

  localparam int unsigned DEF_ADDR_W      = 4;
  localparam int unsigned DEF_STACK_DEPTH = 4;

  // Single operation selected at each active edge
  typedef enum logic [2:0] {
    NONE  = 3'd0,
    INC   = 3'd1,
    LOAD  = 3'd2,
    CALL  = 3'd3,
    RET   = 3'd4,
    CLEAR = 3'd5
  } pc_op_t;

  // Priority decode: CLR > RET > CALL > Lp > Cp; RET/CALL vanish without the stack
  function automatic pc_op_t decode_op(input logic clr, input logic ret, input logic call,
                                       input logic lp, input logic cp, input logic stack_en);
    pc_op_t op;
    op = NONE;
    if (clr)                  op = CLEAR;
    else if (stack_en && ret)  op = RET;
    else if (stack_en && call) op = CALL;
    else if (lp)              op = LOAD;
    else if (cp)              op = INC;
    return op;
  endfunction

endpackage

// File: rtl/sap_program_counter_if.sv
// Control and W-bus signals between the SAP controller and the program counter.
interface sap_program_counter_if #(
  parameter int unsigned ADDR_W = sap_pkg::DEF_ADDR_W
);

  logic              Cp;
  logic              Ep;
  logic              Lp;
  logic              CALL;
  logic              RET;
  logic [ADDR_W-1:0] WBus_in;
  logic [ADDR_W-1:0] WBus_out;
  logic              WBus_oe;
  logic [ADDR_W-1:0] pc;
  logic              stk_empty;
  logic              stk_full;
  logic              stk_err;

  // Controller side
  modport master (
    output Cp, Ep, Lp, CALL, RET, WBus_in,
    input  WBus_out, WBus_oe, pc, stk_empty, stk_full, stk_err
  );

  // Program-counter side
  modport slave (
    input  Cp, Ep, Lp, CALL, RET, WBus_in,
    output WBus_out, WBus_oe, pc, stk_empty, stk_full, stk_err
  );

endinterface

// File: rtl/pc_return_stack.sv
// LIFO of return addresses; only the pointer is reset, entry storage is not.
module pc_return_stack #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              nCLK,
  input  logic              CLR,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [IDX_W-1:0]  top_idx_c;

  assign top_idx_c = IDX_W'(cnt_q - CNT_W'(1));
  assign dout      = mem[top_idx_c];

  // Next entry count; overflow/underflow requests are dropped
  always_comb begin
    cnt_d = cnt_q;
    if (push && !full)       cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !empty)  cnt_d = cnt_q - CNT_W'(1);
  end

  // Pointer and registered status flags
  always_ff @(negedge nCLK) begin
    if (CLR) begin
      cnt_q <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      empty <= (cnt_d == '0);
      full  <= (cnt_d == CNT_W'(DEPTH));
    end
  end

  // Entry storage written at the current count on a push
  always_ff @(negedge nCLK) begin
    if (!CLR && push && !full) mem[IDX_W'(cnt_q)] <= din;
  end

endmodule

// File: rtl/sap_program_counter.sv
// SAP-1 style program counter with optional return-address stack.
// Define PC_STACK_EN to compile in CALL/RET and the stack status flags.
module sap_program_counter
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                 nCLK,
  input  logic                 CLR,
  sap_program_counter_if.slave bus
);

  if (ADDR_W < 2 || ADDR_W > 16 || STACK_DEPTH < 1 || STACK_DEPTH > 16) begin : g_bad_param
    $error("sap_program_counter: ADDR_W must be 2..16 and STACK_DEPTH 1..16");
  end

`ifdef PC_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc_c;
  logic              err_q;
  logic              err_d;
  logic              stk_empty_c;
  logic              stk_full_c;
  pc_op_t            op_c;

  assign pc_inc_c = pc_q + ADDR_W'(1);
  assign op_c     = decode_op(CLR, bus.RET, bus.CALL, bus.Lp, bus.Cp, STACK_EN);

`ifdef PC_STACK_EN
  logic              push_c;
  logic              pop_c;
  logic [ADDR_W-1:0] stk_top_c;

  pc_return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .nCLK  (nCLK),
    .CLR   (CLR),
    .push  (push_c),
    .pop   (pop_c),
    .din   (pc_inc_c),
    .dout  (stk_top_c),
    .empty (stk_empty_c),
    .full  (stk_full_c)
  );
`else
  assign stk_empty_c = 1'b1;
  assign stk_full_c  = 1'b0;
`endif

  // Next count, sticky error and stack requests for the decoded operation
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
`ifdef PC_STACK_EN
    push_c = 1'b0;
    pop_c  = 1'b0;
`endif
    case (op_c)
      CLEAR: begin
        pc_d  = '0;
        err_d = 1'b0;
      end
`ifdef PC_STACK_EN
      RET: begin
        if (stk_empty_c) begin
          err_d = 1'b1;
        end else begin
          pc_d  = stk_top_c;
          pop_c = 1'b1;
        end
      end
      CALL: begin
        if (stk_full_c) begin
          err_d = 1'b1;
        end else begin
          pc_d   = bus.WBus_in;
          push_c = 1'b1;
        end
      end
`endif
      LOAD:    pc_d = bus.WBus_in;
      INC:     pc_d = pc_inc_c;
      default: ;
    endcase
  end

  // Count and error registers, synchronous clear on the falling edge of nCLK
  always_ff @(negedge nCLK) begin
    if (CLR) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  // W bus follows the count directly; drive enable is Ep itself
  assign bus.WBus_out  = pc_q;
  assign bus.WBus_oe   = bus.Ep;
  assign bus.pc        = pc_q;
  assign bus.stk_empty = stk_empty_c;
  assign bus.stk_full  = stk_full_c;
  assign bus.stk_err   = STACK_EN & err_q;

endmodule

// File: tb/tb_sap_program_counter.sv
// Randomized bench for sap_program_counter (ADDR_W=4, STACK_DEPTH=2) against a queue-based model.
module tb_sap_program_counter;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned MODV  = 1 << AW;
`ifdef PC_STACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic nCLK;
  logic CLR;
  int   n_vec;
  int   n_err;

  // reference model state
  int   m_pc;
  int   m_stk[$];
  bit   m_err;
  bit   m_valid;

  sap_program_counter_if #(.ADDR_W(AW)) bus ();

  sap_program_counter #(
    .ADDR_W      (AW),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .nCLK (nCLK),
    .CLR  (CLR),
    .bus  (bus.slave)
  );

  initial begin
    nCLK = 1'b1;
    forever #5 nCLK = ~nCLK;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of controls, check combinational outputs, clock, update model, check state
  task automatic step(input bit clr, input bit cp, input bit ep, input bit lp,
                      input bit call, input bit ret, input int din);
    CLR         = clr;
    bus.Cp      = cp;
    bus.Ep      = ep;
    bus.Lp      = lp;
    bus.CALL    = call;
    bus.RET     = ret;
    bus.WBus_in = 4'(din);
    #1;
    check("wbus_oe", 32'(bus.WBus_oe), 32'(ep));
    if (m_valid) check("wbus_out", 32'(bus.WBus_out), 32'(m_pc));
    @(negedge nCLK);
    #1;
    if (clr) begin
      m_pc = 0;
      m_stk.delete();
      m_err = 1'b0;
      m_valid = 1'b1;
    end else if (EN && ret) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (EN && call) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else begin
        m_stk.push_back((m_pc + 1) % MODV);
        m_pc = din;
      end
    end else if (lp) begin
      m_pc = din;
    end else if (cp) begin
      m_pc = (m_pc + 1) % MODV;
    end
    if (m_valid) begin
      check("pc", 32'(bus.pc), 32'(m_pc));
      check("stk_empty", 32'(bus.stk_empty), 32'(m_stk.size() == 0));
      check("stk_full", 32'(bus.stk_full), 32'(EN && m_stk.size() == DEPTH));
      check("stk_err", 32'(bus.stk_err), 32'(m_err));
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_pc    = 0;
    m_err   = 1'b0;
    m_valid = 1'b0;
    CLR = 1'b0; bus.Cp = 1'b0; bus.Ep = 1'b0; bus.Lp = 1'b0;
    bus.CALL = 1'b0; bus.RET = 1'b0; bus.WBus_in = '0;
    @(negedge nCLK);
    #1;

    // reset, then count through the wrap with the bus enabled
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_pc", 32'(bus.pc), 0);
    check("reset_empty", 32'(bus.stk_empty), 1);
    for (int i = 0; i < 17; i++) step(0, 1, 1, 0, 0, 0, 0);
    check("wrap_pc", 32'(bus.pc), 1);

    // load beats increment
    step(0, 0, 0, 1, 0, 0, 5);
    step(0, 1, 0, 1, 0, 0, 10);
    check("load_beats_inc", 32'(bus.pc), 10);

    if (EN) begin
      // nested calls, overflow, returns, underflow
      step(0, 0, 0, 1, 0, 0, 3);
      step(0, 0, 0, 0, 1, 0, 8);
      step(0, 0, 0, 0, 1, 0, 12);
      check("call_full", 32'(bus.stk_full), 1);
      step(0, 1, 0, 1, 1, 0, 2);
      check("ovf_err", 32'(bus.stk_err), 1);
      check("ovf_pc", 32'(bus.pc), 12);
      step(0, 0, 0, 0, 1, 1, 0);
      check("ret_pc9", 32'(bus.pc), 9);
      step(0, 0, 0, 0, 0, 1, 0);
      check("ret_pc4", 32'(bus.pc), 4);
      step(0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      check("clr_err", 32'(bus.stk_err), 0);
      // return address wraps; CLR beats CALL and RET
      step(0, 0, 0, 1, 0, 0, 15);
      step(0, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0, 1, 0);
      check("ret_wrap", 32'(bus.pc), 0);
      step(0, 0, 0, 0, 1, 0, 5);
      step(1, 1, 0, 1, 1, 1, 9);
      check("clr_over_all", 32'(bus.pc), 0);
    end else begin
      // CALL/RET ignored, Cp still counts
      step(0, 0, 0, 1, 0, 0, 6);
      step(0, 1, 0, 0, 1, 0, 3);
      check("nostk_call_inc", 32'(bus.pc), 7);
      step(0, 1, 0, 0, 0, 1, 3);
      check("nostk_ret_inc", 32'(bus.pc), 8);
      check("nostk_err", 32'(bus.stk_err), 0);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sap_program_counter.md
SAP_PROGRAM_COUNTER -- requirements
Module: sap_program_counter

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the program-counter and W-bus address width (range 2..16).
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the number of return-address entries (range 1..16).
REQ-003 nCLK  in  1  SHALL be the single clock; all state SHALL update on the falling edge of nCLK (rising edge of CLK).
REQ-004 CLR  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 Cp  in  1  SHALL request an increment.
REQ-006 Ep  in  1  SHALL request that the count be driven onto the W bus.
REQ-007 Lp  in  1  SHALL request a load (jump) from WBus_in.
REQ-008 CALL  in  1  SHALL request a push of the return address and a jump to WBus_in.
REQ-009 RET  in  1  SHALL request a pop of the return address into the counter.
REQ-010 WBus_in  in  ADDR_W  SHALL be the jump target.
REQ-011 WBus_out  out  ADDR_W  SHALL carry the current count.
REQ-012 WBus_oe  out  1  SHALL be the W-bus drive enable.
REQ-013 pc  out  ADDR_W  SHALL be a registered copy of the count.
REQ-014 stk_empty, stk_full, stk_err  out  1 each  SHALL give stack status and a sticky error.

Function
REQ-015 WBus_out SHALL equal pc combinationally, and WBus_oe SHALL equal Ep combinationally; the block SHALL contain no internal tristate.
REQ-016 Controls sampled at an edge SHALL take effect on pc at that edge, so the new value is visible one cycle after assertion.
REQ-017 Priority per edge SHALL be CLR > RET > CALL > Lp > Cp; only the highest asserted operation SHALL act.
REQ-018 Cp alone SHALL set pc to pc+1 modulo 2^ADDR_W, so all-ones wraps to 0.
REQ-019 Lp SHALL set pc to WBus_in.
REQ-020 CALL with stack not full SHALL push (pc+1) mod 2^ADDR_W and set pc to WBus_in.
REQ-021 CALL with stack full SHALL leave pc and the stack unchanged and set stk_err.
REQ-022 RET with stack not empty SHALL set pc to the top entry and pop it.
REQ-023 RET with stack empty SHALL leave pc unchanged and set stk_err.
REQ-024 stk_empty SHALL be 1 when the entry count is 0, and stk_full SHALL be 1 when the entry count equals STACK_DEPTH; both SHALL be registered and reflect the post-edge count.
REQ-025 stk_err SHALL remain 1 until CLR.

Reset
REQ-026 CLR SHALL set pc to 0, empty the stack (stk_empty=1, stk_full=0), and clear stk_err at that edge.
REQ-027 CLR SHALL override every concurrent operation, including a CALL or RET mid-sequence.
REQ-028 Stack entry contents need not be reset; only the pointer SHALL be.

Configuration
REQ-029 Macro PC_STACK_EN defined SHALL compile in the return stack and REQ-020 to REQ-025.
REQ-030 Without PC_STACK_EN:
- CALL and RET SHALL be ignored, with priority becoming CLR > Lp > Cp.
- stk_empty SHALL be tied to 1, and stk_full and stk_err to 0.
- No stack storage SHALL be synthesised.

Structure
REQ-031 A shared package sap_pkg SHALL hold the default ADDR_W and STACK_DEPTH constants and the pc_op_t enum (NONE, INC, LOAD, CALL, RET, CLEAR) produced by the priority decode.
REQ-032 The stack SHALL be the sub-module pc_return_stack (push, pop, din, dout, empty, full), instantiated only under PC_STACK_EN.

Verification (ADDR_W=4, STACK_DEPTH=2, PC_STACK_EN defined unless noted)
REQ-033 CLR for 1 edge, then Cp for 17 edges -> pc sequences 1..15, 0, 1; Ep=1 -> WBus_oe=1 and WBus_out=pc in the same cycle.
REQ-034 pc=5 with Lp=1, Cp=1, WBus_in=0xA -> pc=0xA (load beats increment).
REQ-035 pc=3, CALL to 0x8 -> pc=8, stk_empty=0; CALL to 0xC -> pc=0xC, stk_full=1; RET -> pc=9; RET -> pc=4, stk_empty=1.
REQ-036 Stack full, CALL to 0x2 -> pc and stack unchanged, stk_err=1; RET -> pc=9 with stk_err still 1; CLR -> pc=0, stk_err=0.
REQ-037 pc=0xF, CALL to 0x1 -> pushed address 0x0; RET -> pc=0. Same edge asserting CALL, RET and CLR -> pc=0 with stack empty.
REQ-038 PC_STACK_EN undefined: CALL or RET with Cp=1 at pc=6 -> pc=7, stk_empty=1, stk_err=0.
